countdown_timer: RTL and testbench

Countdown timer that runs the opposite direction from the stopwatch. It loads a minutes:seconds preset and counts down to 00:00.00 in hundredth-of-second steps, then raises an alarm. It exposes the same three 7-bit count outputs (hundredths, seconds, minutes), so the existing display mux drives it unchanged. It sits beside the stopwatch under the top-level mode selector.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/tick_div.sv | 39 +++
 rtl/countdown_timer.sv | 157 +++++++++++++++
 tb/tb_countdown_timer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and limits for the countdown timer: FSM states, count
// width, per-field maxima and the preset clamp helper.
package timer_pkg;

    localparam int CNT_W = 7;

    localparam logic [CNT_W-1:0] CS_MAX  = 7'd99;
    localparam logic [CNT_W-1:0] SEC_MAX = 7'd59;
    localparam logic [CNT_W-1:0] MIN_MAX = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Clock-enable divider: one-cycle tick every CLK_DIV enabled cycles,
// counter forced to zero whenever en is low.
module tick_div
    import timer_pkg::*;
#(
    parameter int CLK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst_timer,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_timer) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Minutes:seconds.hundredths countdown with preset load, pause/resume and a
// timed, acknowledgeable alarm once the count reaches zero.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_DIV     = 1_000_000,
    parameter int ALARM_TICKS = 300
) (
    input  logic             clk,
    input  logic             rst_timer,
    input  logic             load,
    input  logic [CNT_W-1:0] set_min,
    input  logic [CNT_W-1:0] set_sec,
    input  logic             run,
    input  logic             alarm_ack,
    output logic [CNT_W-1:0] one_hundredth_sec_count,
    output logic [CNT_W-1:0] sec_count,
    output logic [CNT_W-1:0] min_count,
    output logic             running,
    output logic             done,
    output logic             alarm
);

    localparam int AT_W = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
    localparam logic [AT_W-1:0] AT_LAST = AT_W'(ALARM_TICKS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cs_q, cs_d;
    logic [CNT_W-1:0] sec_q, sec_d;
    logic [CNT_W-1:0] min_q, min_d;
    logic             alarm_q, alarm_d;
    logic [AT_W-1:0]  atick_q, atick_d;

    logic             run_tick;
    logic             alarm_tick;
    logic             div_en;
    logic             alarm_en;

    logic [CNT_W-1:0] cs_dec, sec_dec, min_dec;
    logic [CNT_W-1:0] load_min, load_sec;
    logic             cs_borrow, sec_borrow, dec_zero;

    // Pause or load in the same cycle clears the divider so a resume always
    // waits a full period.
    assign div_en   = (state_q == ST_RUN) && run && !load;
    assign alarm_en = (state_q == ST_DONE) && alarm_q && !alarm_ack && !load;

    tick_div #(.CLK_DIV(CLK_DIV)) u_run_div (
        .clk       (clk),
        .rst_timer (rst_timer),
        .en        (div_en),
        .tick      (run_tick)
    );

    tick_div #(.CLK_DIV(CLK_DIV)) u_alarm_div (
        .clk       (clk),
        .rst_timer (rst_timer),
        .en        (alarm_en),
        .tick      (alarm_tick)
    );

    always_comb begin
        cs_borrow  = (cs_q == '0);
        sec_borrow = cs_borrow && (sec_q == '0);
        cs_dec     = cs_borrow ? CS_MAX : (cs_q - 1'b1);
        sec_dec    = sec_q;
        if (cs_borrow) begin
            sec_dec = (sec_q == '0) ? SEC_MAX : (sec_q - 1'b1);
        end
        min_dec    = sec_borrow ? (min_q - 1'b1) : min_q;
        dec_zero   = (cs_dec == '0) && (sec_dec == '0) && (min_dec == '0);
        load_min   = clamp(set_min, MIN_MAX);
        load_sec   = clamp(set_sec, SEC_MAX);
    end

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        sec_d   = sec_q;
        min_d   = min_q;
        alarm_d = alarm_q;
        atick_d = atick_q;

        if (load) begin
            cs_d    = '0;
            sec_d   = load_sec;
            min_d   = load_min;
            alarm_d = 1'b0;
            atick_d = '0;
            state_d = ((load_min != '0) || (load_sec != '0)) ? ST_ARMED : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_ARMED: begin
                    if (run) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_d = ST_ARMED;
                    end else if (run_tick) begin
                        cs_d  = cs_dec;
                        sec_d = sec_dec;
                        min_d = min_dec;
                        if (dec_zero) begin
                            state_d = ST_DONE;
                            alarm_d = 1'b1;
                            atick_d = '0;
                        end
                    end
                end
                ST_DONE: begin
                    if (alarm_q) begin
                        if (alarm_ack) begin
                            alarm_d = 1'b0;
                        end else if (alarm_tick) begin
                            if (atick_q == AT_LAST) begin
                                alarm_d = 1'b0;
                            end else begin
                                atick_d = atick_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_timer) begin
            state_q <= ST_IDLE;
            cs_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            alarm_q <= 1'b0;
            atick_q <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            alarm_q <= alarm_d;
            atick_q <= atick_d;
        end
    end

    assign one_hundredth_sec_count = cs_q;
    assign sec_count               = sec_q;
    assign min_count               = min_q;
    assign running                 = (state_q == ST_RUN);
    assign done                    = (state_q == ST_DONE);
    assign alarm                   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer with CLK_DIV=4, ALARM_TICKS=3:
// expectations are built from a total-hundredths count and compared per cycle.
module tb_countdown_timer;

    localparam int CLK_DIV     = 4;
    localparam int ALARM_TICKS = 3;

    logic       clk = 1'b0;
    logic       rst_timer = 1'b1;
    logic       load = 1'b0;
    logic [6:0] set_min = '0;
    logic [6:0] set_sec = '0;
    logic       run = 1'b0;
    logic       alarm_ack = 1'b0;
    logic [6:0] one_hundredth_sec_count, sec_count, min_count;
    logic       running, done, alarm;

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];
    logic [23:0] exp_v;
    logic [23:0] obs_w;

    countdown_timer #(.CLK_DIV(CLK_DIV), .ALARM_TICKS(ALARM_TICKS)) dut (
        .clk                     (clk),
        .rst_timer               (rst_timer),
        .load                    (load),
        .set_min                 (set_min),
        .set_sec                 (set_sec),
        .run                     (run),
        .alarm_ack               (alarm_ack),
        .one_hundredth_sec_count (one_hundredth_sec_count),
        .sec_count               (sec_count),
        .min_count               (min_count),
        .running                 (running),
        .done                    (done),
        .alarm                   (alarm)
    );

    always #5 clk = ~clk;

    assign obs_w = {one_hundredth_sec_count, sec_count, min_count, running, done, alarm};

    // Expected output word from a total count in hundredths of a second.
    function automatic logic [23:0] mk_exp(input int t, input bit r, input bit d, input bit a);
        logic [6:0] cs, sc, mn;
        cs = 7'(t % 100);
        sc = 7'((t / 100) % 60);
        mn = 7'(t / 6000);
        return {cs, sc, mn, r, d, a};
    endfunction

    function automatic string show(input logic [23:0] v);
        return $sformatf("%0d:%0d.%0d running=%0b done=%0b alarm=%0b",
                         v[9:3], v[16:10], v[23:17], v[2], v[1], v[0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_timer = 1'b1;
        step();
        rst_timer = 1'b0;
        exp_q.push_back(mk_exp(0, 0, 0, 0));
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL reset: got %s, expected %s", show(obs_w), show(exp_v));
        end
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(mk_exp(0, 0, 0, 0));
            step();
            exp_v = exp_q.pop_front(); checks++;
            if (obs_w !== exp_v) begin
                errors++;
                $display("FAIL idle_run cyc=%0d: got %s, expected %s", i, show(obs_w), show(exp_v));
            end
        end
        run = 1'b0;
        $display("test_reset: reset and idle-with-run checked");
    endtask

    task automatic test_countdown();
        int t;
        bit d;
        set_min = 7'd0; set_sec = 7'd2; load = 1'b1;
        exp_q.push_back(mk_exp(200, 0, 0, 0));
        step();
        load = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL load_0_02: got %s, expected %s", show(obs_w), show(exp_v));
        end
        run = 1'b1;
        exp_q.push_back(mk_exp(200, 1, 0, 0));
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL run_start: got %s, expected %s", show(obs_w), show(exp_v));
        end
        for (int k = 1; k <= 815; k++) begin
            d = (k >= 800);
            t = d ? 0 : 200 - k / 4;
            exp_q.push_back(mk_exp(t, !d, d, d && (k < 800 + ALARM_TICKS * CLK_DIV)));
            step();
            exp_v = exp_q.pop_front(); checks++;
            if (obs_w !== exp_v) begin
                errors++;
                $display("FAIL countdown k=%0d: got %s, expected %s", k, show(obs_w), show(exp_v));
            end
        end
        run = 1'b0;
        $display("test_countdown: 0:02 to zero with 12-cycle alarm checked");
    endtask

    task automatic test_pause();
        set_min = 7'd1; set_sec = 7'd0; load = 1'b1;
        exp_q.push_back(mk_exp(6000, 0, 0, 0));
        step();
        load = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL load_1_00: got %s, expected %s", show(obs_w), show(exp_v));
        end
        run = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            exp_q.push_back(mk_exp(6000 - k / 4, 1, 0, 0));
            step();
            exp_v = exp_q.pop_front(); checks++;
            if (obs_w !== exp_v) begin
                errors++;
                $display("FAIL pre_pause k=%0d: got %s, expected %s", k, show(obs_w), show(exp_v));
            end
        end
        // The divider is at its last count here: the tick coincides with run falling.
        run = 1'b0;
        for (int p = 1; p <= 10; p++) begin
            exp_q.push_back(mk_exp(5997, 0, 0, 0));
            step();
            exp_v = exp_q.pop_front(); checks++;
            if (obs_w !== exp_v) begin
                errors++;
                $display("FAIL pause p=%0d: got %s, expected %s", p, show(obs_w), show(exp_v));
            end
        end
        run = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            exp_q.push_back(mk_exp(5997 - k / 4, 1, 0, 0));
            step();
            exp_v = exp_q.pop_front(); checks++;
            if (obs_w !== exp_v) begin
                errors++;
                $display("FAIL resume k=%0d: got %s, expected %s", k, show(obs_w), show(exp_v));
            end
        end
        run = 1'b0;
        exp_q.push_back(mk_exp(5995, 0, 0, 0));
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL pause_end: got %s, expected %s", show(obs_w), show(exp_v));
        end
        $display("test_pause: pause hold and resume latency checked");
    endtask

    task automatic test_clamp();
        set_min = 7'd120; set_sec = 7'd75; load = 1'b1;
        exp_q.push_back(mk_exp(599900, 0, 0, 0));
        step();
        load = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL clamp_load: got %s, expected %s", show(obs_w), show(exp_v));
        end
        alarm_ack = 1'b1;
        exp_q.push_back(mk_exp(599900, 0, 0, 0));
        step();
        alarm_ack = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL ack_armed: got %s, expected %s", show(obs_w), show(exp_v));
        end
        run = 1'b1;
        exp_q.push_back(mk_exp(599900, 1, 0, 0));
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL clamp_armed_run: got %s, expected %s", show(obs_w), show(exp_v));
        end
        set_min = 7'd0; set_sec = 7'd0; load = 1'b1;
        exp_q.push_back(mk_exp(0, 0, 0, 0));
        step();
        load = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL load_zero: got %s, expected %s", show(obs_w), show(exp_v));
        end
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(mk_exp(0, 0, 0, 0));
            step();
            exp_v = exp_q.pop_front(); checks++;
            if (obs_w !== exp_v) begin
                errors++;
                $display("FAIL zero_preset cyc=%0d: got %s, expected %s", i, show(obs_w), show(exp_v));
            end
        end
        set_min = 7'd0; set_sec = 7'd5; load = 1'b1;
        exp_q.push_back(mk_exp(500, 0, 0, 0));
        step();
        load = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL load_with_run: got %s, expected %s", show(obs_w), show(exp_v));
        end
        exp_q.push_back(mk_exp(500, 1, 0, 0));
        step();
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL load_with_run_next: got %s, expected %s", show(obs_w), show(exp_v));
        end
        run = 1'b0;
        step();
        $display("test_clamp: clamp, zero preset and load-with-run checked");
    endtask

    task automatic test_alarm_ack();
        int t;
        bit d;
        for (int pass = 0; pass < 2; pass++) begin
            run = 1'b0;
            set_min = 7'd0; set_sec = 7'd1; load = 1'b1;
            exp_q.push_back(mk_exp(100, 0, 0, 0));
            step();
            load = 1'b0;
            exp_v = exp_q.pop_front(); checks++;
            if (obs_w !== exp_v) begin
                errors++;
                $display("FAIL ack_load pass=%0d: got %s, expected %s", pass, show(obs_w), show(exp_v));
            end
            run = 1'b1;
            for (int k = 0; k <= 401; k++) begin
                d = (k >= 400);
                t = d ? 0 : 100 - k / 4;
                exp_q.push_back(mk_exp(t, !d, d, d));
                step();
                exp_v = exp_q.pop_front(); checks++;
                if (obs_w !== exp_v) begin
                    errors++;
                    $display("FAIL to_alarm pass=%0d k=%0d: got %s, expected %s", pass, k, show(obs_w), show(exp_v));
                end
            end
            // Now in the 2nd alarm cycle.
            if (pass == 0) begin
                alarm_ack = 1'b1;
                exp_q.push_back(mk_exp(0, 0, 1, 0));
                step();
                alarm_ack = 1'b0;
                exp_v = exp_q.pop_front(); checks++;
                if (obs_w !== exp_v) begin
                    errors++;
                    $display("FAIL ack_drop: got %s, expected %s", show(obs_w), show(exp_v));
                end
                for (int i = 0; i < 15; i++) begin
                    exp_q.push_back(mk_exp(0, 0, 1, 0));
                    step();
                    exp_v = exp_q.pop_front(); checks++;
                    if (obs_w !== exp_v) begin
                        errors++;
                        $display("FAIL ack_hold cyc=%0d: got %s, expected %s", i, show(obs_w), show(exp_v));
                    end
                end
            end else begin
                run = 1'b0;
                set_min = 7'd0; set_sec = 7'd3; load = 1'b1;
                exp_q.push_back(mk_exp(300, 0, 0, 0));
                step();
                load = 1'b0;
                exp_v = exp_q.pop_front(); checks++;
                if (obs_w !== exp_v) begin
                    errors++;
                    $display("FAIL load_in_alarm: got %s, expected %s", show(obs_w), show(exp_v));
                end
                for (int i = 0; i < 14; i++) begin
                    exp_q.push_back(mk_exp(300, 0, 0, 0));
                    step();
                    exp_v = exp_q.pop_front(); checks++;
                    if (obs_w !== exp_v) begin
                        errors++;
                        $display("FAIL rearmed_hold cyc=%0d: got %s, expected %s", i, show(obs_w), show(exp_v));
                    end
                end
            end
        end
        run = 1'b0;
        $display("test_alarm_ack: ack on 2nd alarm cycle and load during alarm checked");
    endtask

    task automatic test_reset_midrun();
        set_min = 7'd0; set_sec = 7'd31; load = 1'b1;
        exp_q.push_back(mk_exp(3100, 0, 0, 0));
        step();
        load = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL load_0_31: got %s, expected %s", show(obs_w), show(exp_v));
        end
        run = 1'b1;
        for (int k = 0; k <= 200; k++) begin
            exp_q.push_back(mk_exp(3100 - k / 4, 1, 0, 0));
            step();
            exp_v = exp_q.pop_front(); checks++;
            if (obs_w !== exp_v) begin
                errors++;
                $display("FAIL to_30_50 k=%0d: got %s, expected %s", k, show(obs_w), show(exp_v));
            end
        end
        rst_timer = 1'b1;
        exp_q.push_back(mk_exp(0, 0, 0, 0));
        step();
        rst_timer = 1'b0;
        exp_v = exp_q.pop_front(); checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL reset_midrun: got %s, expected %s", show(obs_w), show(exp_v));
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk_exp(0, 0, 0, 0));
            step();
            exp_v = exp_q.pop_front(); checks++;
            if (obs_w !== exp_v) begin
                errors++;
                $display("FAIL post_reset_idle cyc=%0d: got %s, expected %s", i, show(obs_w), show(exp_v));
            end
        end
        run = 1'b0;
        $display("test_reset_midrun: reset at 00:30.50 checked");
    endtask

    initial begin
        step();
        test_reset();
        test_countdown();
        test_pause();
        test_clamp();
        test_alarm_ack();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
